alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execute-stage consumer of the 5-bit ALU operation code produced by ALU control, placed directly downstream of it.
- Registers operands under a valid/ready handshake and computes single-cycle ops in one cycle.
- Performs SRL/SLL iteratively, one bit per cycle, to save area.
- Presents the result, zero flag and illegal flag, held until the consumer accepts them.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount width; maximum shift is 2^SHAMT_WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid_i  input  1  operation and operands valid.
- in_ready_o  output  1  unit can accept an operation.
- alu_operation_i  input  5  operation code from ALU control.
- operand_a_i  input  DATA_WIDTH  rs value; for JAL carries PC+4.
- operand_b_i  input  DATA_WIDTH  rt value or extended immediate.
- shamt_i  input  SHAMT_WIDTH  shift amount for SRL/SLL.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- result_o  output  DATA_WIDTH  computed result.
- zero_o  output  1  result_o == 0.
- illegal_o  output  1  operation code not recognised.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; out_valid_o=0, result_o=0, zero_o=0, illegal_o=0, in_ready_o=1; shift counter=0.
- Reset mid-shift or in DONE: returns to IDLE next edge and discards the pending result.
- States:
  - IDLE: in_ready_o=1. Accept on in_valid_i & in_ready_o; latch op, a, b, shamt.
    - Shift op with shamt>0 -> SHIFT (acc=b, cnt=shamt).
    - Otherwise -> DONE, with the result computed from the latched inputs.
  - SHIFT: in_ready_o=0. Each cycle acc shifts by 1 (SRL: logical right, zero fill; SLL: left, zero fill) and cnt decrements. When cnt==1, the final shift is done and the state moves to DONE.
  - DONE: out_valid_o=1; result_o, zero_o and illegal_o are stable. On out_ready_i -> IDLE, with out_valid_o=0 the next cycle. Without out_ready_i, outputs hold indefinitely.
- Latency: accept at edge N -> out_valid_o high from cycle N+1+k, where k=shamt for shifts and k=0 otherwise.
- Throughput: at most one operation per 2 cycles; no accept while in DONE, even if out_ready_i=1 in the same cycle.
- Operation codes (mod 2^DATA_WIDTH, no overflow trap):
  - 00000 ADD, 01000 LW, 01001 SW: a+b.
  - 00001 SUB, 01010 BEQ, 01011 BNE: a-b; zero_o drives the branch decision downstream.
  - 00010 OR: a|b.
  - 00011 ORI: a | {0,b[15:0]}.
  - 00111 ANDI: a & {0,b[15:0]}.
  - 01101 AND: a&b.
  - 01100 NOR: ~(a|b).
  - 00100 SRL: b>>shamt.
  - 00101 SLL: b<<shamt.
  - 00110 LUI: {b[15:0],16'h0}.
  - 01110 JMP: 0.
  - 01111 JAL: a (PC+4 pass-through).
  - Any other code, including 11111: result 0, zero_o=1, illegal_o=1, 1-cycle latency.
- Boundaries:
  - shamt=0 shift: result=b, latency 1.
  - shamt=31: latency 32.
  - Inputs change while busy: ignored; the latched copies are used.
  - in_valid_i low in IDLE: no state change.

Decomposition:
- Shared package mips_alu_pkg:
  - 5-bit localparams for every operation code above, e.g. ALU_ADD=5'b00000 ... ALU_JAL=5'b01111, ALU_ILLEGAL=5'b11111.
  - State encoding IDLE/SHIFT/DONE.
  - Helper constant LUI_SHIFT=16.
- One sub-module, alu_comb_core: purely combinational result for all non-iterative ops plus the illegal flag.
- The FSM, handshake and serial shifter stay in alu_exec_unit.

Test Plan:
- Reset held 3 cycles during SHIFT -> next cycle out_valid_o=0, in_ready_o=1, result_o=0.
- ADD a=32'h7FFF_FFFF, b=1 accepted at N -> out_valid_o at N+1, result 32'h8000_0000, zero_o=0. Then SUB a=5, b=5 -> result 0, zero_o=1.
- SLL b=32'h0000_0001, shamt=31 -> out_valid_o exactly at N+32, result 32'h8000_0000; in_ready_o=0 throughout. SRL shamt=0, b=32'hA5A5_A5A5 -> result unchanged at N+1.
- LUI b=32'h0000_1234 -> 32'h1234_0000. ORI a=32'hF000_0000, b=32'hFFFF_00FF -> 32'hF000_00FF. NOR a=0, b=0 -> 32'hFFFF_FFFF.
- DONE with out_ready_i=0 for 5 cycles, in_valid_i=1 -> result held, no accept. Raise out_ready_i -> IDLE next cycle, new op accepted the cycle after.
- Op 11111 and op 10000 -> result 0, illegal_o=1, zero_o=1, latency 1. JAL a=32'h0040_0008 -> result 32'h0040_0008, illegal_o=0.

Source files
------------

// File: rtl/mips_alu_pkg.sv
// Operation codes, FSM state encoding and constants shared by the
// execute-stage ALU unit and its combinational core.
package mips_alu_pkg;

  localparam logic [4:0] ALU_ADD     = 5'b00000;
  localparam logic [4:0] ALU_SUB     = 5'b00001;
  localparam logic [4:0] ALU_OR      = 5'b00010;
  localparam logic [4:0] ALU_ORI     = 5'b00011;
  localparam logic [4:0] ALU_SRL     = 5'b00100;
  localparam logic [4:0] ALU_SLL     = 5'b00101;
  localparam logic [4:0] ALU_LUI     = 5'b00110;
  localparam logic [4:0] ALU_ANDI    = 5'b00111;
  localparam logic [4:0] ALU_LW      = 5'b01000;
  localparam logic [4:0] ALU_SW      = 5'b01001;
  localparam logic [4:0] ALU_BEQ     = 5'b01010;
  localparam logic [4:0] ALU_BNE     = 5'b01011;
  localparam logic [4:0] ALU_NOR     = 5'b01100;
  localparam logic [4:0] ALU_AND     = 5'b01101;
  localparam logic [4:0] ALU_JMP     = 5'b01110;
  localparam logic [4:0] ALU_JAL     = 5'b01111;
  localparam logic [4:0] ALU_ILLEGAL = 5'b11111;

  localparam int LUI_SHIFT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: result for every non-iterative operation plus
// the illegal-opcode flag. Shift codes return b unshifted (the shamt=0 case).
module alu_comb_core
  import mips_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [4:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
);

  logic [DATA_WIDTH-1:0] imm_zext;

  assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, b[15:0]};

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      ALU_ADD, ALU_LW, ALU_SW:    result = a + b;
      ALU_SUB, ALU_BEQ, ALU_BNE:  result = a - b;
      ALU_OR:                     result = a | b;
      ALU_ORI:                    result = a | imm_zext;
      ALU_ANDI:                   result = a & imm_zext;
      ALU_AND:                    result = a & b;
      ALU_NOR:                    result = ~(a | b);
      ALU_SRL, ALU_SLL:           result = b;
      ALU_LUI:                    result = imm_zext << LUI_SHIFT;
      ALU_JMP:                    result = '0;
      ALU_JAL:                    result = a;
      default:                    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides; SRL/SLL are
// performed serially one bit per cycle, everything else in a single cycle.
module alu_exec_unit
  import mips_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [4:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  operand_a_i,
  input  logic [DATA_WIDTH-1:0]  operand_b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   zero_o,
  output logic                   illegal_o
);

  state_t                 state_reg, state_next;
  logic [DATA_WIDTH-1:0]  acc_reg, acc_next;
  logic [DATA_WIDTH-1:0]  result_reg, result_next;
  logic [SHAMT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                   left_reg, left_next;
  logic                   zero_reg, zero_next;
  logic                   illegal_reg, illegal_next;

  logic [DATA_WIDTH-1:0]  core_result;
  logic                   core_illegal;
  logic [DATA_WIDTH-1:0]  acc_shifted;
  logic                   is_shift;

  // The core sees the ports directly: in IDLE the accepted operands are
  // exactly the values being latched, so no extra register stage is needed.
  alu_comb_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .op      (alu_operation_i),
    .a       (operand_a_i),
    .b       (operand_b_i),
    .result  (core_result),
    .illegal (core_illegal)
  );

  assign is_shift    = (alu_operation_i == ALU_SRL) || (alu_operation_i == ALU_SLL);
  assign acc_shifted = left_reg ? {acc_reg[DATA_WIDTH-2:0], 1'b0}
                                : {1'b0, acc_reg[DATA_WIDTH-1:1]};

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    result_next  = result_reg;
    cnt_next     = cnt_reg;
    left_next    = left_reg;
    zero_next    = zero_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid_i) begin
          left_next = (alu_operation_i == ALU_SLL);
          if (is_shift && (shamt_i != '0)) begin
            state_next = SHIFT;
            acc_next   = operand_b_i;
            cnt_next   = shamt_i;
          end else begin
            state_next   = DONE;
            result_next  = core_result;
            zero_next    = (core_result == '0);
            illegal_next = core_illegal;
          end
        end
      end
      SHIFT: begin
        acc_next = acc_shifted;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == SHAMT_WIDTH'(1)) begin
          state_next   = DONE;
          result_next  = acc_shifted;
          zero_next    = (acc_shifted == '0);
          illegal_next = 1'b0;
        end
      end
      DONE: begin
        if (out_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      result_reg  <= '0;
      cnt_reg     <= '0;
      left_reg    <= 1'b0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      result_reg  <= result_next;
      cnt_reg     <= cnt_next;
      left_reg    <= left_next;
      zero_reg    <= zero_next;
      illegal_reg <= illegal_next;
    end
  end

  assign in_ready_o  = (state_reg == IDLE);
  assign out_valid_o = (state_reg == DONE);
  assign result_o    = result_reg;
  assign zero_o      = zero_reg;
  assign illegal_o   = illegal_reg;

endmodule
